// File: rtl/reg_file_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : reg_file_param_if
// Purpose  : Write, read, clear and status signals of the parametrised
//            register file, grouped into one bundle.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              write;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] out1_address;
  logic [ADDR_W-1:0] out2_address;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              clear;
  logic              busy;
  logic              write_drop;

  // The datapath side drives requests and consumes read data and status.
  modport master (
    output write, in_address, in_data, out1_address, out2_address, clear,
    input  out1, out2, busy, write_drop
  );

  // The register file side.
  modport slave (
    input  write, in_address, in_data, out1_address, out2_address, clear,
    output out1, out2, busy, write_drop
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : reg_file_param
// Purpose  : DEPTH x DATA_W register file, one write port, two read ports,
//            optional registered reads with write-first bypass, and a
//            sequential clear engine that reports BUSY.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int REG_READ = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_param_if.slave bus
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              drop_q;
  logic [DATA_W-1:0] regs [DEPTH];

  logic sweeping;
  logic wr_en;

  // Writes are only honoured while the clear engine is idle.
  assign sweeping = (state == SWEEP);
  assign wr_en    = bus.write && !sweeping;

  // Clear-engine FSM: one entry zeroed per cycle, counter wraps at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= bus.write && sweeping;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            state   <= SWEEP;
            counter <= '0;
          end
        end
        SWEEP: begin
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register array: a write and a sweep step can never share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.in_address] <= bus.in_data;
    end else if (sweeping) begin
      regs[counter] <= '0;
    end
  end

  assign bus.busy       = sweeping;
  assign bus.write_drop = drop_q;

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] nxt1;
      logic [DATA_W-1:0] nxt2;

      // Post-edge value of each read address: write wins, then sweep zero.
      always_comb begin
        nxt1 = regs[bus.out1_address];
        nxt2 = regs[bus.out2_address];
        if (wr_en && (bus.in_address == bus.out1_address)) begin
          nxt1 = bus.in_data;
        end else if (sweeping && (counter == bus.out1_address)) begin
          nxt1 = '0;
        end
        if (wr_en && (bus.in_address == bus.out2_address)) begin
          nxt2 = bus.in_data;
        end else if (sweeping && (counter == bus.out2_address)) begin
          nxt2 = '0;
        end
      end

      // Registered read ports.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bus.out1 <= '0;
          bus.out2 <= '0;
        end else begin
          bus.out1 <= nxt1;
          bus.out2 <= nxt2;
        end
      end
    end else begin : g_comb_read
      assign bus.out1 = regs[bus.out1_address];
      assign bus.out2 = regs[bus.out2_address];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_reg_file_param
// Purpose  : Directed scoreboard bench for reg_file_param in three builds:
//            8x8 combinational, 8x8 registered, 16x16 combinational.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_reg_file_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #50 clk = ~clk;

  reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) ifa ();
  reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) ifb ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

  reg_file_param #(.DATA_W(8),  .ADDR_W(3), .REG_READ(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  reg_file_param #(.DATA_W(8),  .ADDR_W(3), .REG_READ(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  reg_file_param #(.DATA_W(16), .ADDR_W(4), .REG_READ(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wr_a(input int a, input int d);
    ifa.write = 1'b1; ifa.in_address = 3'(a); ifa.in_data = 8'(d);
    tick();
    ifa.write = 1'b0;
  endtask

  task automatic wr_b(input int a, input int d);
    ifb.write = 1'b1; ifb.in_address = 3'(a); ifb.in_data = 8'(d);
    tick();
    ifb.write = 1'b0;
  endtask

  task automatic wr_c(input int a, input int d);
    ifc.write = 1'b1; ifc.in_address = 4'(a); ifc.in_data = 16'(d);
    tick();
    ifc.write = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int a, input int v);
    ifa.out1_address = 3'(a);
    expect_val(tag, 32'(v));
    #1;
    check(32'(ifa.out1));
  endtask

  task automatic chk_c(input string tag, input int a, input int v);
    ifc.out1_address = 4'(a);
    expect_val(tag, 32'(v));
    #1;
    check(32'(ifc.out1));
  endtask

  task automatic chk_sig(input string tag, input logic [31:0] obs, input int v);
    expect_val(tag, 32'(v));
    check(obs);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    ifa.write = 0; ifa.in_address = 0; ifa.in_data = 0; ifa.clear = 0;
    ifa.out1_address = 0; ifa.out2_address = 0;
    ifb.write = 0; ifb.in_address = 0; ifb.in_data = 0; ifb.clear = 0;
    ifb.out1_address = 0; ifb.out2_address = 0;
    ifc.write = 0; ifc.in_address = 0; ifc.in_data = 0; ifc.clear = 0;
    ifc.out1_address = 0; ifc.out2_address = 0;

    // Reset state
    #20;
    chk_sig("a_busy_rst", 32'(ifa.busy), 0);
    chk_sig("a_drop_rst", 32'(ifa.write_drop), 0);
    chk_a("a_r0_rst", 0, 0);
    chk_sig("b_out1_rst", 32'(ifb.out1), 0);
    chk_sig("c_busy_rst", 32'(ifc.busy), 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic write / dual read, combinational
    wr_a(2, 95);
    wr_a(1, 28);
    ifa.out1_address = 3'd2; ifa.out2_address = 3'd1;
    expect_val("a_out1_r2", 95);
    expect_val("a_out2_r1", 28);
    #1;
    check(32'(ifa.out1));
    check(32'(ifa.out2));
    for (int i = 0; i < 8; i++) begin
      if (i != 1 && i != 2) chk_a("a_other_zero", i, 0);
    end

    // Sweep with a dropped write
    for (int i = 0; i < 8; i++) wr_a(i, i + 1);
    ifa.clear = 1'b1;
    tick();                                   // edge N
    ifa.clear = 1'b0;
    chk_sig("a_busy_n", 32'(ifa.busy), 1);
    tick(); tick(); tick();                   // edge N+3
    chk_a("a_sw_r0", 0, 0);
    chk_a("a_sw_r1", 1, 0);
    chk_a("a_sw_r2", 2, 0);
    chk_a("a_sw_r3", 3, 4);
    chk_sig("a_busy_n3", 32'(ifa.busy), 1);
    ifa.write = 1'b1; ifa.in_address = 3'd7; ifa.in_data = 8'hAA;
    tick();                                   // edge N+4, dropped
    ifa.write = 1'b0;
    chk_sig("a_drop_hi", 32'(ifa.write_drop), 1);
    tick();                                   // edge N+5
    chk_sig("a_drop_lo", 32'(ifa.write_drop), 0);
    chk_sig("a_busy_n5", 32'(ifa.busy), 1);
    tick(); tick();                           // edge N+7
    chk_sig("a_busy_n7", 32'(ifa.busy), 1);
    tick();                                   // edge N+8
    chk_sig("a_busy_n8", 32'(ifa.busy), 0);
    for (int i = 0; i < 8; i++) chk_a("a_swept_zero", i, 0);
    wr_a(7, 8'hAA);                           // edge N+9, accepted
    chk_a("a_r7_after", 7, 8'hAA);
    chk_sig("a_drop_after", 32'(ifa.write_drop), 0);

    // Simultaneous write + clear, then CLEAR mid-sweep
    ifa.write = 1'b1; ifa.in_address = 3'd0; ifa.in_data = 8'h55; ifa.clear = 1'b1;
    tick();                                   // edge M
    ifa.write = 1'b0; ifa.clear = 1'b0;
    chk_a("a_sim_r0_55", 0, 8'h55);
    chk_sig("a_sim_busy", 32'(ifa.busy), 1);
    tick();                                   // edge M+1
    chk_a("a_sim_r0_0", 0, 0);
    ifa.clear = 1'b1;
    tick();                                   // edge M+2, ignored
    ifa.clear = 1'b0;
    tick(); tick(); tick(); tick(); tick();   // edge M+7
    chk_sig("a_sim_busy_m7", 32'(ifa.busy), 1);
    tick();                                   // edge M+8
    chk_sig("a_sim_busy_m8", 32'(ifa.busy), 0);

    // Async reset mid-sweep
    for (int i = 0; i < 8; i++) wr_a(i, 8'h30 + i);
    ifa.clear = 1'b1;
    tick();                                   // edge P
    ifa.clear = 1'b0;
    tick(); tick();                           // edge P+2
    ifa.write = 1'b1; ifa.in_address = 3'd6; ifa.in_data = 8'h77;
    tick();                                   // edge P+3, dropped
    ifa.write = 1'b0;
    chk_sig("a_pre_rst_drop", 32'(ifa.write_drop), 1);
    chk_sig("a_pre_rst_busy", 32'(ifa.busy), 1);
    chk_a("a_pre_rst_r5", 5, 8'h35);
    #3 rst_n = 1'b0;
    #1;
    chk_sig("a_arst_busy", 32'(ifa.busy), 0);
    chk_sig("a_arst_drop", 32'(ifa.write_drop), 0);
    for (int i = 0; i < 8; i++) chk_a("a_arst_zero", i, 0);
    #5 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_sig("a_no_resume", 32'(ifa.busy), 0);
    wr_a(5, 8'h11);
    chk_a("a_post_rst_r5", 5, 8'h11);
    chk_a("a_post_rst_r6", 6, 0);

    // Registered reads: write-first bypass
    wr_b(4, 6);
    ifb.out1_address = 3'd4; ifb.out2_address = 3'd4;
    tick();
    chk_sig("b_r4_old", 32'(ifb.out1), 6);
    ifb.write = 1'b1; ifb.in_address = 3'd4; ifb.in_data = 8'd15;
    tick();
    ifb.write = 1'b0;
    chk_sig("b_bypass_out1", 32'(ifb.out1), 15);
    chk_sig("b_bypass_out2", 32'(ifb.out2), 15);

    // Registered reads: clear bypass
    wr_b(0, 8'h21);
    wr_b(1, 8'h22);
    ifb.out1_address = 3'd0; ifb.out2_address = 3'd1;
    tick();
    chk_sig("b_r0_pre", 32'(ifb.out1), 8'h21);
    chk_sig("b_r1_pre", 32'(ifb.out2), 8'h22);
    ifb.clear = 1'b1;
    tick();                                   // edge N
    ifb.clear = 1'b0;
    chk_sig("b_r0_n", 32'(ifb.out1), 8'h21);
    tick();                                   // edge N+1 zeros r0
    chk_sig("b_r0_cleared", 32'(ifb.out1), 0);
    chk_sig("b_r1_unswept", 32'(ifb.out2), 8'h22);
    tick();                                   // edge N+2 zeros r1
    chk_sig("b_r1_cleared", 32'(ifb.out2), 0);
    for (int i = 0; i < 7; i++) tick();

    // 16x16 build: sweep then async reset mid-sweep
    for (int i = 0; i < 16; i++) wr_c(i, 16'h1000 + i);
    ifc.clear = 1'b1;
    tick();                                   // edge N
    ifc.clear = 1'b0;
    tick(); tick(); tick();                   // edge N+3
    chk_c("c_sw_r0", 0, 0);
    chk_c("c_sw_r2", 2, 0);
    chk_c("c_sw_r3", 3, 16'h1003);
    chk_c("c_sw_r15", 15, 16'h100F);
    chk_sig("c_busy", 32'(ifc.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_sig("c_arst_busy", 32'(ifc.busy), 0);
    for (int i = 0; i < 16; i++) chk_c("c_arst_zero", i, 0);
    #5 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_sig("c_no_resume", 32'(ifc.busy), 0);
    wr_c(15, 16'hBEEF);
    chk_c("c_post_rst_r15", 15, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the team's 8x8 register file: a DEPTH x DATA_W register array with one write port and two read ports. It adds a selectable registered read mode with write-first bypass, a multi-cycle sequential clear engine with a BUSY flag, and an asynchronous active-low reset. It sits between instruction decode/ALU and writeback in the single-cycle datapath and drops in for the fixed 8x8 file when DATA_W=8, ADDR_W=3, REG_READ=0.

## Interface
- DATA_W, 8: width of each register and of the data ports.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- REG_READ, 0: 0 = combinational read ports; 1 = read ports registered on CLK with write-first bypass.
- CLK  input  1  single clock; all state changes on rising edge except reset.
- RESET_N  input  1  reset is asynchronous and active-low.
- WRITE  input  1  write enable, sampled at posedge CLK.
- INADDRESS  input  ADDR_W  write address.
- IN  input  DATA_W  write data.
- OUT1ADDRESS, OUT2ADDRESS  input  ADDR_W  read addresses.
- OUT1, OUT2  output  DATA_W  read data.
- CLEAR  input  1  request to zero all registers sequentially, sampled at posedge CLK.
- BUSY  output  1  high while the clear engine is running.
- WRITE_DROP  output  1  one-cycle registered pulse: a write was discarded because BUSY was high.

## Operation
- Reset (RESET_N=0, any time, including mid-clear): all registers = 0, clear counter = 0, BUSY = 0, WRITE_DROP = 0, registered OUT1/OUT2 = 0. In combinational mode OUT1/OUT2 show the zeroed array. Reset overrides every other input.
- Write: at a posedge with WRITE=1 and BUSY=0, register[INADDRESS] <= IN. WRITE=1 with BUSY=1 performs no write and sets WRITE_DROP=1 for the next cycle. Otherwise WRITE_DROP=0.
- Read, REG_READ=0: OUTn = register[OUTnADDRESS] combinationally, with no modelled delay. A write becomes visible right after the edge that performs it.
- Read, REG_READ=1: at each posedge, OUTn <= the post-edge value of register[OUTnADDRESS]. If the same edge writes that address, the new IN is returned. If the same edge clears that address, 0 is returned.
- Clear engine states:
  - IDLE: BUSY=0. If CLEAR=1 at a posedge, go to SWEEP with counter=0.
  - SWEEP: BUSY=1. Each posedge zeros register[counter] and increments counter. When the edge zeros register[DEPTH-1], go to IDLE and counter wraps to 0.
- A sweep takes exactly DEPTH cycles. CLEAR while in SWEEP is ignored, with no restart and no queueing.
- CLEAR and WRITE at the same idle edge: the write is performed and the sweep starts, so the written entry is later zeroed. The sweep itself zeros register 0 starting on the following edge.
- Reads during SWEEP return current contents: already-swept entries read 0, unswept entries keep their old value.
- Both read ports may address the same register, and either may match INADDRESS. There is no port priority.

## Timing
- Write latency: 1 edge. Combinational read visible in the same cycle after the edge. Registered read: data for an address sampled at edge N appears after edge N.
- CLEAR at edge N: BUSY=1 from edge N until edge N+DEPTH. Register k is zeroed at edge N+1+k. BUSY=0 after edge N+DEPTH, and writes are accepted at edge N+DEPTH+1.
- WRITE_DROP asserts after the edge that dropped the write and lasts one cycle per dropped write.
- Deassertion of RESET_N is sampled synchronously: the first state change is at the first posedge with RESET_N=1.

## Test plan
- Reset/write/read (REG_READ=0): pulse RESET_N low, write 95 to r2 and 28 to r1, read OUT1ADDRESS=2, OUT2ADDRESS=1 -> OUT1=95, OUT2=28. All other registers read 0.
- Bypass (REG_READ=1): r4=6; at one edge write 15 to r4 with OUT1ADDRESS=4 -> OUT1=15 after that edge, never 6.
- Sweep (DEPTH=8): fill r0..r7 with 1..8, then assert CLEAR at edge N.
  - BUSY=1 for exactly 8 cycles.
  - After edge N+3, r0..r2=0 and r3=4.
  - All registers read 0 after edge N+8.
- Dropped write: during the sweep, write 0xAA to r7 -> WRITE_DROP=1 for one cycle and r7 ends at 0. The same write one cycle after BUSY falls -> r7=0xAA.
- Simultaneous events: CLEAR plus a write of 0x55 to r0 at one idle edge -> r0 reads 0x55 for one cycle, then 0. A second CLEAR mid-sweep does not extend BUSY.
- Async reset mid-sweep: drop RESET_N between edges at sweep step 3 -> BUSY, WRITE_DROP and all registers are 0 immediately. After release, no sweep resumes. Repeat with DATA_W=16, ADDR_W=4.
